fifo_push_arbiter: RTL and testbench

//  Shares the write port of one std_fifo between N_REQ producers.
//  - Round-robin, burst-locked arbitration into the FIFO push/data inputs, with backpressure from full/almost_full.
//  - Sequences a FIFO clear on request, only between bursts.
//  - Sits directly in front of std_fifo; o_push/o_data/o_clear drive its i_push/i_data/i_clear.

---
 rtl/fifo_push_arbiter_if.sv | 22 ++
 rtl/fifo_push_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_fifo_push_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_push_arbiter_if.sv
// ----------------------------------------------------------------------------
// fifo_push_arbiter_if
// Write-side bundle between fifo_push_arbiter and one std_fifo.
//   push        : push strobe into the FIFO (i_push)
//   data        : word to store (i_data)
//   clear       : one-cycle FIFO clear (i_clear)
//   full        : FIFO cannot accept a word this cycle (o_full)
//   almost_full : FIFO is about to fill (o_almost_full)
// Modports: master = arbiter side, slave = FIFO side.
// ----------------------------------------------------------------------------
interface fifo_push_arbiter_if #(
   parameter int WIDTH = 8
) ();
   logic             push;
   logic [WIDTH-1:0] data;
   logic             clear;
   logic             full;
   logic             almost_full;

   modport master (output push, data, clear, input full, almost_full);
   modport slave  (input push, data, clear, output full, almost_full);
endinterface

// File: rtl/fifo_push_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_push_arbiter
// Shares the write port of one std_fifo between N_REQ producers using
// round-robin, burst-locked arbitration with backpressure from full and
// almost_full. Also sequences a FIFO clear on request, only between bursts.
//
// Ports:
//   i_clk, i_rst   clock (rising edge) and synchronous active-high reset
//   i_req          producer i has a word on its i_data slice
//   i_data         producer words, slice i = [i*WIDTH +: WIDTH]
//   o_ack          word of producer i consumed this cycle
//   o_grant        one-hot registered grant, 0 outside of a burst
//   i_flush        pulse requesting a FIFO clear
//   o_flush_busy   flush pending or in progress
//   o_starved      per-producer starvation flags
//   fifo           master side of the FIFO write bundle
//
// Optional feature: define FIFO_ARB_STARVE_EN to build the per-producer
// saturating wait counters behind o_starved. Without it o_starved is 0.
// ----------------------------------------------------------------------------
module fifo_push_arbiter #(
   parameter int N_REQ        = 4,
   parameter int WIDTH        = 8,
   parameter int MAX_BURST    = 4,
   parameter int STARVE_LIMIT = 64
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [N_REQ-1:0]       i_req,
   input  logic [N_REQ*WIDTH-1:0] i_data,
   output logic [N_REQ-1:0]       o_ack,
   output logic [N_REQ-1:0]       o_grant,
   input  logic                   i_flush,
   output logic                   o_flush_busy,
   output logic [N_REQ-1:0]       o_starved,
   fifo_push_arbiter_if.master    fifo
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BURST = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   if (N_REQ < 1 || N_REQ > 16 || MAX_BURST < 1 || MAX_BURST > 255 ||
       STARVE_LIMIT < 1) begin : g_bad_param
      $error("fifo_push_arbiter: parameter out of range");
   end

   logic [1:0]       state_q,      state_d;
   logic [IDX_W-1:0] gnt_idx_q,    gnt_idx_d;
   logic [N_REQ-1:0] gnt_q,        gnt_d;
   logic [IDX_W-1:0] rr_ptr_q,     rr_ptr_d;
   logic [7:0]       beat_q,       beat_d;
   logic             flush_pend_q, flush_pend_d;

   logic             win_found;
   logic [IDX_W-1:0] win_idx;
   logic             gnt_req;
   logic             push;
   logic [7:0]       beat_inc;
   logic [WIDTH-1:0] slice [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_slice
      assign slice[g] = i_data[g*WIDTH +: WIDTH];
   end

   // Round-robin search: first requester strictly after rr_ptr, wrapping,
   // so the producer that just finished a burst has the lowest priority.
   always_comb begin
      logic [IDX_W-1:0] cand;
      // NOTE: every combinational output gets a default before any branch so
      // no path leaves it unassigned, which would otherwise infer a latch.
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int off = 1; off <= N_REQ; off++) begin
         cand = IDX_W'((int'(rr_ptr_q) + off) % N_REQ);
         if (!win_found && i_req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign gnt_req  = i_req[gnt_idx_q];
   assign push     = (state_q == S_BURST) && gnt_req && !fifo.full;
   assign beat_inc = beat_q + 8'd1;

   always_comb begin
      state_d      = state_q;
      gnt_idx_d    = gnt_idx_q;
      gnt_d        = gnt_q;
      rr_ptr_d     = rr_ptr_q;
      beat_d       = beat_q;
      flush_pend_d = flush_pend_q | i_flush;

      case (state_q)
         S_IDLE: begin
            // A flush request outranks any new grant.
            if (flush_pend_q || i_flush) begin
               state_d = S_FLUSH;
            end else if (win_found) begin
               state_d   = S_BURST;
               gnt_idx_d = win_idx;
               gnt_d     = N_REQ'(1) << win_idx;
               beat_d    = '0;
            end
         end
         S_BURST: begin
            if (push) begin
               beat_d = beat_inc;
               if (beat_inc == 8'(MAX_BURST) || fifo.almost_full) begin
                  state_d  = S_IDLE;
                  gnt_d    = '0;
                  rr_ptr_d = gnt_idx_q;
                  beat_d   = '0;
               end
            end else if (!gnt_req) begin
               state_d  = S_IDLE;
               gnt_d    = '0;
               rr_ptr_d = gnt_idx_q;
               beat_d   = '0;
            end
            // Otherwise the FIFO is full: hold grant and beat count.
         end
         S_FLUSH: begin
            flush_pend_d = 1'b0;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values from before this edge, independent of statement order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= S_IDLE;
         gnt_idx_q    <= '0;
         gnt_q        <= '0;
         rr_ptr_q     <= IDX_W'(N_REQ - 1);
         beat_q       <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         gnt_idx_q    <= gnt_idx_d;
         gnt_q        <= gnt_d;
         rr_ptr_q     <= rr_ptr_d;
         beat_q       <= beat_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   assign o_grant      = gnt_q;
   assign o_ack        = push ? gnt_q : '0;
   assign o_flush_busy = flush_pend_q || (state_q == S_FLUSH);
   assign fifo.push    = push;
   assign fifo.data    = slice[gnt_idx_q];
   assign fifo.clear   = (state_q == S_FLUSH);

`ifdef FIFO_ARB_STARVE_EN
   logic [7:0] wait_q [N_REQ];
   logic [7:0] wait_d [N_REQ];

   // A producer counts cycles spent requesting without being served.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         wait_d[i] = '0;
         if (i_req[i] && !o_ack[i]) begin
            wait_d[i] = (wait_q[i] == 8'hFF) ? wait_q[i] : wait_q[i] + 8'd1;
         end
      end
   end

   // NOTE: the counter array is small and its flags are visible outputs, so
   // every entry is reset rather than left to settle after reset.
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < N_REQ; i++) begin
         if (i_rst) wait_q[i] <= '0;
         else       wait_q[i] <= wait_d[i];
      end
   end

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         o_starved[i] = (int'(wait_q[i]) >= STARVE_LIMIT);
      end
   end
`else
   assign o_starved = '0;
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_push_arbiter
// Directed bench for fifo_push_arbiter (N_REQ=4, WIDTH=8, MAX_BURST=4,
// STARVE_LIMIT=8). A transaction-level model (current owner, words sent,
// last winner, flush bookkeeping) predicts every output each cycle; directed
// sections add hand-computed push/clear counts and grant orders.
// ----------------------------------------------------------------------------
module tb_fifo_push_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int MB = 4;
   localparam int SL = 8;

`ifdef FIFO_ARB_STARVE_EN
   localparam bit STARVE_ON = 1'b1;
`else
   localparam bit STARVE_ON = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] data_in;
   logic [N-1:0]   ack;
   logic [N-1:0]   grant;
   logic           flush;
   logic           busy;
   logic [N-1:0]   starved;

   fifo_push_arbiter_if #(.WIDTH(W)) fifo_if ();

   fifo_push_arbiter #(
      .N_REQ(N), .WIDTH(W), .MAX_BURST(MB), .STARVE_LIMIT(SL)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req        (req),
      .i_data       (data_in),
      .o_ack        (ack),
      .o_grant      (grant),
      .i_flush      (flush),
      .o_flush_busy (busy),
      .o_starved    (starved),
      .fifo         (fifo_if)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   int  m_owner = -1;     // producer currently bursting, -1 when none
   int  m_last  = N - 1;  // producer that finished the most recent burst
   int  m_words = 0;      // words already pushed in this burst
   bit  m_pend  = 1'b0;   // a clear has been requested
   bit  m_clearing = 1'b0;// this cycle is the clear cycle
   int  m_wait [N];
   bit  m_valid = 1'b0;

   // Observation logs used by the directed sections.
   int  push_cnt  = 0;
   int  clear_cnt = 0;
   int  gnt_log [$];
   logic [N-1:0] prev_grant = '0;

   initial begin
      for (int i = 0; i < N; i++) m_wait[i] = 0;
      forever begin
         logic [N-1:0] e_grant, e_ack, e_starved;
         bit           e_push, np;
         @(negedge clk);
         e_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
         e_push  = (m_owner >= 0) && req[m_owner] && !fifo_if.full;
         e_ack   = e_push ? e_grant : '0;
         for (int i = 0; i < N; i++) e_starved[i] = STARVE_ON && (m_wait[i] >= SL);

         if (m_valid) begin
            check("grant",   grant,           e_grant);
            check("onehot",  $onehot0(grant), 1);
            check("push",    fifo_if.push,    e_push);
            check("ack",     ack,             e_ack);
            check("clear",   fifo_if.clear,   m_clearing);
            check("busy",    busy,            m_pend || m_clearing);
            check("starved", starved,         e_starved);
            if (m_owner >= 0) check("data", fifo_if.data, data_in[m_owner*W +: W]);
            push_cnt  += int'(fifo_if.push);
            clear_cnt += int'(fifo_if.clear);
            if (grant != '0 && grant != prev_grant) begin
               for (int i = 0; i < N; i++) if (grant[i]) gnt_log.push_back(i);
            end
            prev_grant = grant;
         end

         // Advance the model by one clock using the inputs of this cycle.
         if (rst) begin
            m_owner = -1; m_last = N - 1; m_words = 0;
            m_pend = 1'b0; m_clearing = 1'b0;
            for (int i = 0; i < N; i++) m_wait[i] = 0;
            m_valid = 1'b1;
         end else begin
            np = m_clearing ? 1'b0 : (m_pend || flush);
            for (int i = 0; i < N; i++)
               m_wait[i] = (req[i] && !e_ack[i]) ? ((m_wait[i] < 255) ? m_wait[i] + 1 : 255) : 0;
            if (m_clearing) begin
               m_clearing = 1'b0;
            end else if (m_owner >= 0) begin
               if (e_push) begin
                  m_words++;
                  if (m_words == MB || fifo_if.almost_full) begin
                     m_last = m_owner; m_owner = -1;
                  end
               end else if (!req[m_owner]) begin
                  m_last = m_owner; m_owner = -1;
               end
            end else if (m_pend || flush) begin
               m_clearing = 1'b1;
            end else begin
               for (int k = 1; k <= N; k++) begin
                  if (req[(m_last + k) % N]) begin
                     m_owner = (m_last + k) % N; m_words = 0;
                     break;
                  end
               end
            end
            m_pend = np;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(2);
      rst = 1'b0; req = '0; flush = 1'b0;
      fifo_if.full = 1'b0; fifo_if.almost_full = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      int p0, c0, g0;
      logic [N-1:0] exp_starved;
      int exp_order [5] = '{0, 1, 2, 3, 0};
      rst = 1'b1; req = '0; data_in = '0; flush = 1'b0;
      fifo_if.full = 1'b0; fifo_if.almost_full = 1'b0;

      // T1: reset state, single producer, 4-word bursts separated by one idle cycle
      do_reset();
      #1;
      check("rst_grant", grant, 0);
      check("rst_push",  fifo_if.push, 0);
      check("rst_clear", fifo_if.clear, 0);
      check("rst_busy",  busy, 0);
      check("rst_ack",   ack, 0);
      check("rst_starved", starved, 0);
      req = 4'b0001; data_in = 32'h0000_00A5;
      p0 = push_cnt; g0 = gnt_log.size();
      step(2);
      check("t1_push_c2", fifo_if.push, 1);
      check("t1_data_c2", fifo_if.data, 8'hA5);
      step(4);
      check("t1_pushes", push_cnt - p0, 4);
      step(1);
      check("t1_pushes_next", push_cnt - p0, 5);
      check("t1_bursts", gnt_log.size() - g0, 2);
      check("t1_second_gnt", gnt_log[g0 + 1], 0);
      req = '0;
      step(3);

      // T2: all requesting -> grants 0,1,2,3,0 with 4 pushes each
      do_reset();
      req = 4'b1111; data_in = 32'h4433_2211;
      p0 = push_cnt; g0 = gnt_log.size();
      step(25);
      check("t2_pushes", push_cnt - p0, 20);
      check("t2_bursts", gnt_log.size() - g0, 5);
      for (int i = 0; i < 5; i++) check($sformatf("t2_order%0d", i), gnt_log[g0 + i], exp_order[i]);
      req = '0;
      step(3);

      // T3: producer 2, full for 3 cycles mid-burst
      do_reset();
      req = 4'b0100; data_in = 32'h005C_0000;
      p0 = push_cnt; g0 = gnt_log.size();
      step(3);
      fifo_if.full = 1'b1;
      step(1);
      check("t3_hold_grant", grant, 4'b0100);
      check("t3_stall_push", fifo_if.push, 0);
      step(2);
      fifo_if.full = 1'b0;
      step(2);
      req = '0;
      step(2);
      check("t3_pushes", push_cnt - p0, 4);
      check("t3_bursts", gnt_log.size() - g0, 1);
      check("t3_gnt", gnt_log[g0], 2);

      // T4: almost_full at first push ends burst after one word
      do_reset();
      req = 4'b0011; data_in = 32'h0000_BBAA;
      p0 = push_cnt; g0 = gnt_log.size();
      step(1);
      fifo_if.almost_full = 1'b1;
      step(1);
      fifo_if.almost_full = 1'b0;
      step(2);
      req = '0;
      step(3);
      check("t4_pushes", push_cnt - p0, 2);
      check("t4_bursts", gnt_log.size() - g0, 2);
      check("t4_first",  gnt_log[g0], 0);
      check("t4_next",   gnt_log[g0 + 1], 1);

      // T5: flush during beat 2 (second pulse absorbed), one clear, grants resume
      do_reset();
      req = 4'b0001; data_in = 32'h0000_00A5;
      p0 = push_cnt; c0 = clear_cnt;
      step(3);
      flush = 1'b1;
      step(2);
      flush = 1'b0;
      step(1);
      check("t5_clear_c6", fifo_if.clear, 1);
      check("t5_busy_c6",  busy, 1);
      step(1);
      check("t5_busy_c7",  busy, 0);
      check("t5_clear_c7", fifo_if.clear, 0);
      step(3);
      check("t5_pushes", push_cnt - p0, 6);
      check("t5_clears", clear_cnt - c0, 1);
      req = '0;
      step(3);

      // T6: starvation flag while full, released by the first ack
      do_reset();
      fifo_if.full = 1'b1;
      req = 4'b0010; data_in = 32'h0000_C300;
      step(7);
      check("t6_starved_c7", starved, 0);
      step(1);
      exp_starved = STARVE_ON ? 4'b0010 : 4'b0000;
      check("t6_starved_c8", starved, exp_starved);
      step(2);
      fifo_if.full = 1'b0;
      step(1);
      check("t6_starved_after_ack", starved, 0);
      req = '0;
      step(3);

      // T7: reset mid-burst discards the partial beat count
      do_reset();
      req = 4'b0001; data_in = 32'h0000_00A5;
      step(3);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check("t7_grant_after_rst", grant, 0);
      check("t7_push_after_rst",  fifo_if.push, 0);
      p0 = push_cnt;
      step(6);
      check("t7_pushes", push_cnt - p0, 4);
      req = '0;
      step(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
